// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the MEM stage (master) and data_memory_lsu (slave).
// Both sides use valid/ready: a beat transfers on a clock edge where valid && ready are both high.
interface data_memory_lsu_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressed RISC-V data memory with funct3 sized loads/stores and a one-entry response register.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them down.
module data_memory_lsu #(
   parameter int XLEN   = 64,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   data_memory_lsu_if.slave   bus
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   logic [XLEN-1:0]  r_mem [DEPTH];
   logic             r_resp_valid;
   logic             r_resp_err;
   logic [XLEN-1:0]  r_resp_rdata;

   logic             w_accept;
   logic             w_legal;
   logic             w_misaligned;
   logic             w_err;
   logic             w_we;
   logic [1:0]       w_size_log2;
   logic [OFF_W-1:0] w_mask;
   logic [OFF_W-1:0] w_off;
   logic [IDX_W-1:0] w_idx;
   logic [NB-1:0]    w_be;
   int               w_size;
   logic [XLEN-1:0]  w_wdata_sh;
   logic [XLEN-1:0]  w_word;
   logic [XLEN-1:0]  w_rshift;
   logic [XLEN-1:0]  w_ext;
   logic             w_unused;

   assign bus.req_ready  = !r_resp_valid || bus.resp_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_err   = r_resp_err;

   assign w_accept    = bus.req_valid && bus.req_ready;
   assign w_size_log2 = bus.req_funct3[1:0];
   assign w_idx       = bus.req_addr[OFF_W +: IDX_W];
   // Address bits above the memory size are dropped so accesses wrap.
   assign w_unused    = ^bus.req_addr[ADDR_W-1:OFF_W+IDX_W];

   always_comb begin
      w_legal = 1'b1;
      if (bus.req_write) begin
         w_legal = !bus.req_funct3[2] && !(XLEN == 32 && w_size_log2 == 2'd3);
      end else begin
         w_legal = (bus.req_funct3 != 3'b111) &&
                   !(XLEN == 32 && (w_size_log2 == 2'd3 || bus.req_funct3 == 3'b110));
      end
   end

   always_comb begin
      w_mask = '0;
      for (int b = 0; b < OFF_W; b++) begin
         w_mask[b] = (b < int'(w_size_log2));
      end
   end

   assign w_misaligned = |(bus.req_addr[OFF_W-1:0] & w_mask);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_err = !w_legal || w_misaligned;
   assign w_off = bus.req_addr[OFF_W-1:0];
`else
   assign w_err = !w_legal;
   assign w_off = bus.req_addr[OFF_W-1:0] & ~w_mask;
`endif

   assign w_we = w_accept && bus.req_write && !w_err;

   always_comb begin
      w_size = 1 << w_size_log2;
      w_be   = '0;
      for (int i = 0; i < NB; i++) begin
         w_be[i] = (i >= int'(w_off)) && (i < int'(w_off) + w_size);
      end
   end

   assign w_wdata_sh = bus.req_wdata << {w_off, 3'b000};
   assign w_word     = r_mem[w_idx];
   assign w_rshift   = w_word >> {w_off, 3'b000};

   // funct3[2] set means an unsigned load: fill with zeros instead of the MSB.
   always_comb begin
      w_ext = w_rshift;
      case (w_size_log2)
         2'd0: begin
            w_ext       = {XLEN{!bus.req_funct3[2] && w_rshift[7]}};
            w_ext[7:0]  = w_rshift[7:0];
         end
         2'd1: begin
            w_ext       = {XLEN{!bus.req_funct3[2] && w_rshift[15]}};
            w_ext[15:0] = w_rshift[15:0];
         end
         2'd2: begin
            w_ext       = {XLEN{!bus.req_funct3[2] && w_rshift[31]}};
            w_ext[31:0] = w_rshift[31:0];
         end
         default: w_ext = w_rshift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else if (w_accept) begin
         r_resp_valid <= 1'b1;
         r_resp_err   <= w_err;
         r_resp_rdata <= (bus.req_write || w_err) ? '0 : w_ext;
      end else if (bus.resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu (XLEN=64, DEPTH=64); expectations follow DMEM_MISALIGN_TRAP_EN.
module tb_data_memory_lsu;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [63:0] exp_q[$];

   data_memory_lsu_if #(.XLEN(64), .ADDR_W(32)) bus ();

   data_memory_lsu #(.XLEN(64), .DEPTH(64), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [63:0] d, output logic [63:0] rd, output logic er);
      int n;
      n = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.resp_ready = 1'b1;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("resp_valid", 64'(bus.resp_valid), 64'd1);
      rd = bus.resp_rdata;
      er = bus.resp_err;
   endtask

   task automatic do_txn(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [63:0] d,
                         input logic [63:0] exp_rd, input logic exp_er);
      logic [63:0] rd;
      logic        er;
      txn(w, f3, a, d, rd, er);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, 64'(er), 64'(exp_er));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // leave an error response pending, then reset asynchronously mid-cycle
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'b111;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("pend_valid", 64'(bus.resp_valid), 64'd1);
      check("pend_err", 64'(bus.resp_err), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_err", 64'(bus.resp_err), 64'd0);
      check("rst_rdata", bus.resp_rdata, 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      do_txn("sd10", 1'b1, 3'b011, 32'h10, 64'h1122334455667788, 64'h0, 1'b0);
      do_txn("ld10", 1'b0, 3'b011, 32'h10, 64'h0, 64'h1122334455667788, 1'b0);

      do_txn("sd20", 1'b1, 3'b011, 32'h20, 64'h0, 64'h0, 1'b0);
      do_txn("sb23", 1'b1, 3'b000, 32'h23, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0);
      do_txn("ld20", 1'b0, 3'b011, 32'h20, 64'h0, 64'h00000000AB000000, 1'b0);
      do_txn("lb23", 1'b0, 3'b000, 32'h23, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0);
      do_txn("lbu23", 1'b0, 3'b100, 32'h23, 64'h0, 64'h00000000000000AB, 1'b0);

      do_txn("sw30", 1'b1, 3'b010, 32'h30, 64'h80001234, 64'h0, 1'b0);
      do_txn("lw30", 1'b0, 3'b010, 32'h30, 64'h0, 64'hFFFFFFFF80001234, 1'b0);
      do_txn("lwu30", 1'b0, 3'b110, 32'h30, 64'h0, 64'h0000000080001234, 1'b0);
      do_txn("lh32", 1'b0, 3'b001, 32'h32, 64'h0, 64'hFFFFFFFFFFFF8000, 1'b0);
      do_txn("lhu32", 1'b0, 3'b101, 32'h32, 64'h0, 64'h0000000000008000, 1'b0);

      // backpressure: two loads queued behind a stalled response
      do_txn("sd40", 1'b1, 3'b011, 32'h40, 64'hA5A5_0000_1111_2222, 64'h0, 1'b0);
      do_txn("sd48", 1'b1, 3'b011, 32'h48, 64'h0F0F_3333_4444_5555, 64'h0, 1'b0);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b011;
      bus.req_addr   = 32'h40;
      exp_q.push_back(64'hA5A5_0000_1111_2222);
      @(posedge clk);
      @(negedge clk);
      bus.req_addr = 32'h48;
      exp_q.push_back(64'h0F0F_3333_4444_5555);
      check("bp_ready0", 64'(bus.req_ready), 64'd0);
      check("bp_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_first", bus.resp_rdata, exp_q[0]);
      @(negedge clk);
      check("bp_stable", bus.resp_rdata, exp_q[0]);
      check("bp_ready0b", 64'(bus.req_ready), 64'd0);
      bus.resp_ready = 1'b1;
      #1;
      check("bp_ready1", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      void'(exp_q.pop_front());
      check("bp_second_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_second", bus.resp_rdata, exp_q[0]);
      bus.req_addr = 32'h40;
      exp_q.push_back(64'hA5A5_0000_1111_2222);
      @(posedge clk);
      @(negedge clk);
      void'(exp_q.pop_front());
      check("bp_third", bus.resp_rdata, exp_q[0]);
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      void'(exp_q.pop_front());
      check("bp_drained", 64'(bus.resp_valid), 64'd0);
      check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      do_txn("sw30b", 1'b1, 3'b010, 32'h30, 64'hDEADBEEF, 64'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
      do_txn("lw31", 1'b0, 3'b010, 32'h31, 64'h0, 64'h0, 1'b1);
      do_txn("lh33", 1'b0, 3'b001, 32'h33, 64'h0, 64'h0, 1'b1);
      do_txn("sw31", 1'b1, 3'b010, 32'h31, 64'h12345678, 64'h0, 1'b1);
      do_txn("lw30b", 1'b0, 3'b010, 32'h30, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0);
`else
      do_txn("lw31", 1'b0, 3'b010, 32'h31, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0);
      do_txn("lh33", 1'b0, 3'b001, 32'h33, 64'h0, 64'hFFFFFFFFFFFFDEAD, 1'b0);
      do_txn("sw31", 1'b1, 3'b010, 32'h31, 64'h12345678, 64'h0, 1'b0);
      do_txn("lw30b", 1'b0, 3'b010, 32'h30, 64'h0, 64'h0000000012345678, 1'b0);
`endif

      do_txn("ld111", 1'b0, 3'b111, 32'h10, 64'h0, 64'h0, 1'b1);
      do_txn("st100", 1'b1, 3'b100, 32'h10, 64'hFF, 64'h0, 1'b1);
      do_txn("ld10b", 1'b0, 3'b011, 32'h10, 64'h0, 64'h1122334455667788, 1'b0);

      do_txn("sd208", 1'b1, 3'b011, 32'h208, 64'h5A5A, 64'h0, 1'b0);
      do_txn("ld008", 1'b0, 3'b011, 32'h008, 64'h0, 64'h5A5A, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
